// File: rtl/dmem_line_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_line_responder
//  Purpose  : Memory-side responder for the dcache2mem line interface.
//             Services line refills and write-backs against a word-organised
//             backing store with programmable latency, one word per beat,
//             a single-cycle completion ack and kill aborts.
//  Options  : DMEM_RESP_PERF_CNT_EN adds saturating read/write/kill counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_line_responder #(
    parameter int WORD_BITS       = 32,
    parameter int LINE_WORDS      = 4,
    parameter int MEM_DEPTH_WORDS = 4096,
    parameter int LATENCY         = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dcache2mem_req_i,
    input  logic                            dcache2mem_wr_i,
    input  logic                            dcache2mem_kill_i,
    input  logic [31:0]                     dcache2mem_addr_i,
    input  logic [LINE_WORDS*WORD_BITS-1:0] dcache2mem_data_i,
    output logic                            mem2dcache_ack_o,
    output logic [LINE_WORDS*WORD_BITS-1:0] mem2dcache_data_o,
    output logic                            busy_o
`ifdef DMEM_RESP_PERF_CNT_EN
    ,
    output logic [31:0]                     rd_cnt_o,
    output logic [31:0]                     wr_cnt_o,
    output logic [31:0]                     kill_cnt_o
`endif
);

    localparam int LINE_BITS = LINE_WORDS * WORD_BITS;
    localparam int AW        = $clog2(MEM_DEPTH_WORDS);
    localparam int BW        = $clog2(LINE_WORDS);
    localparam int OFFS      = $clog2(WORD_BITS / 8);
    localparam int LCW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [LCW-1:0] LAT_LAST  = LCW'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [BW-1:0]  BEAT_LAST = BW'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [LCW-1:0]       lat_q, lat_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 wr_q, wr_d;
    logic [AW-1:0]        base_q, base_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic [LINE_BITS-1:0] data_q, data_d;

    logic [WORD_BITS-1:0] mem [MEM_DEPTH_WORDS];

    logic [31:0]          word_idx;
    logic [AW-1:0]        beat_addr;
    logic [WORD_BITS-1:0] rd_word;
    logic [WORD_BITS-1:0] wr_word;
    logic                 mem_we;
    logic                 accept;
    logic                 unused_addr_bits;

    // Line base: byte address -> word index, line-aligned, wrapped into the array
    assign word_idx         = dcache2mem_addr_i >> OFFS;
    assign unused_addr_bits = ^{word_idx[31:AW], word_idx[BW-1:0]};
    assign beat_addr        = base_q | AW'(beat_q);
    assign rd_word          = mem[beat_addr];
    assign wr_word          = line_q[beat_q*WORD_BITS +: WORD_BITS];
    assign accept           = (state_q == S_IDLE) && dcache2mem_req_i && !dcache2mem_kill_i;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            wr_q    <= 1'b0;
            base_q  <= '0;
            line_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            wr_q    <= wr_d;
            base_q  <= base_d;
            line_q  <= line_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: kill aborts WAIT/XFER, ACK always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (LATENCY > 0) ? S_WAIT : S_XFER;
            S_WAIT: begin
                if (dcache2mem_kill_i)     state_d = S_IDLE;
                else if (lat_q == LAT_LAST) state_d = S_XFER;
            end
            S_XFER: begin
                if (dcache2mem_kill_i)       state_d = S_IDLE;
                else if (beat_q == BEAT_LAST) state_d = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture at accept, count wait cycles, move one word per beat
    always_comb begin
        lat_d  = lat_q;
        beat_d = beat_q;
        wr_d   = wr_q;
        base_d = base_q;
        line_d = line_q;
        data_d = data_q;
        mem_we = 1'b0;
        if (accept) begin
            lat_d  = '0;
            beat_d = '0;
            wr_d   = dcache2mem_wr_i;
            base_d = {word_idx[AW-1:BW], {BW{1'b0}}};
            line_d = dcache2mem_data_i;
        end
        if (state_q == S_WAIT) begin
            lat_d = lat_q + 1'b1;
        end
        // A beat in the kill cycle is dropped; earlier write beats stay in memory
        if ((state_q == S_XFER) && !dcache2mem_kill_i) begin
            if (wr_q) begin
                mem_we = 1'b1;
            end else begin
                line_d[beat_q*WORD_BITS +: WORD_BITS] = rd_word;
            end
            beat_d = beat_q + 1'b1;
            // Refill result becomes visible in the ack cycle and is held until the next one
            if ((beat_q == BEAT_LAST) && !wr_q) begin
                data_d = line_d;
            end
        end
    end

    // Backing store write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[beat_addr] <= wr_word;
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        mem2dcache_ack_o  = (state_q == S_ACK);
        busy_o            = (state_q != S_IDLE);
        mem2dcache_data_o = data_q;
    end

`ifdef DMEM_RESP_PERF_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;

    // Saturating event counters
    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        kill_cnt_d = kill_cnt_q;
        if ((state_q == S_ACK) && !wr_q && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_d = rd_cnt_q + 32'd1;
        if ((state_q == S_ACK) && wr_q && (wr_cnt_q != 32'hFFFF_FFFF))  wr_cnt_d = wr_cnt_q + 32'd1;
        if (((state_q == S_WAIT) || (state_q == S_XFER)) && dcache2mem_kill_i
            && (kill_cnt_q != 32'hFFFF_FFFF))
            kill_cnt_d = kill_cnt_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            kill_cnt_q <= '0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    assign rd_cnt_o   = rd_cnt_q;
    assign wr_cnt_o   = wr_cnt_q;
    assign kill_cnt_o = kill_cnt_q;
`endif

endmodule
`default_nettype wire
